// File: rtl/sdff_pipe.sv
// Stallable multi-stage delay line of synchronous-reset flops with per-stage valid and occupancy count.
// Optional FLUSH port and line invalidation are compiled in when SDFF_PIPE_FLUSH_EN is defined.
module sdff_pipe #(
  parameter  int               WIDTH   = 2,
  parameter  int               DEPTH   = 4,
  parameter  logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int               CNTW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             SRST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
`ifdef SDFF_PIPE_FLUSH_EN
  input  logic             FLUSH,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [CNTW-1:0]  COUNT
);

  logic [DEPTH-1:0][WIDTH-1:0] data_reg;
  logic [DEPTH-1:0][WIDTH-1:0] data_next;
  logic [DEPTH-1:0]            vld_reg;
  logic [DEPTH-1:0]            vld_next;
  logic [CNTW-1:0]             count_reg;
  logic [CNTW-1:0]             count_next;
  logic                        flush;

`ifdef SDFF_PIPE_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  // Stage 0 takes the input beat; every later stage takes its predecessor.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign data_next[gi] = D;
        assign vld_next[gi]  = D_VALID;
      end else begin : g_body
        assign data_next[gi] = data_reg[gi-1];
        assign vld_next[gi]  = vld_reg[gi-1];
      end
    end
  endgenerate

  // One beat in, one beat out per enabled edge keeps the count within 0..DEPTH.
  assign count_next = count_reg + CNTW'(D_VALID) - CNTW'(vld_reg[DEPTH-1]);

  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      data_reg  <= {DEPTH{RST_VAL}};
      vld_reg   <= '0;
      count_reg <= '0;
    end else begin
      // Data keeps shifting under a flush; only the valid flags are cleared.
      if (EN) begin
        data_reg <= data_next;
      end
      if (flush) begin
        vld_reg   <= '0;
        count_reg <= '0;
      end else if (EN) begin
        vld_reg   <= vld_next;
        count_reg <= count_next;
      end
    end
  end

  assign Q       = data_reg[DEPTH-1];
  assign Q_VALID = vld_reg[DEPTH-1];
  assign COUNT   = count_reg;

endmodule

// File: tb/tb_sdff_pipe.sv
// Self-checking bench for sdff_pipe (WIDTH=2, DEPTH=4) against a queue-of-beats reference model.
// Flush scenarios are exercised when SDFF_PIPE_FLUSH_EN is defined.
module tb_sdff_pipe;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             srst_n;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CNTW-1:0]  count;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
  } beat_t;

  // line[0] is the newest beat, line[DEPTH-1] is the beat on the output.
  beat_t line[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(2'b00)) dut (
    .CLK     (clk),
    .SRST_N  (srst_n),
    .EN      (en),
    .D       (d),
    .D_VALID (d_valid),
`ifdef SDFF_PIPE_FLUSH_EN
    .FLUSH   (flush),
`endif
    .Q       (q),
    .Q_VALID (q_valid),
    .COUNT   (count)
  );

  task automatic model_reset();
    line.delete();
    for (int i = 0; i < DEPTH; i++) line.push_back('{data: 2'b00, valid: 1'b0});
  endtask

  task automatic model_edge(input logic r, input logic e, input logic f,
                            input logic [WIDTH-1:0] dd, input logic dv);
    if (!r) begin
      model_reset();
    end else begin
      if (f) begin
        for (int i = 0; i < DEPTH; i++) line[i].valid = 1'b0;
      end
      if (e) begin
        line.push_front('{data: dd, valid: dv & ~f});
        void'(line.pop_back());
      end
    end
  endtask

  function automatic int model_count();
    int n = 0;
    foreach (line[i]) n += int'(line[i].valid);
    return n;
  endfunction

  task automatic check(input string tag);
    logic [CNTW-1:0] exp_cnt;
    exp_cnt = CNTW'(model_count());
    total++;
    assert (q === line[DEPTH-1].data) else begin
      bad++;
      $error("FAIL %s Q got=%0h exp=%0h", tag, q, line[DEPTH-1].data);
    end
    total++;
    assert (q_valid === line[DEPTH-1].valid) else begin
      bad++;
      $error("FAIL %s Q_VALID got=%0b exp=%0b", tag, q_valid, line[DEPTH-1].valid);
    end
    total++;
    assert (count === exp_cnt) else begin
      bad++;
      $error("FAIL %s COUNT got=%0d exp=%0d", tag, count, exp_cnt);
    end
  endtask

  // Apply inputs, clock one edge, advance the model, check just after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic f,
                      input logic [WIDTH-1:0] dd, input logic dv);
    srst_n  = r;
    en      = e;
    flush   = f;
    d       = dd;
    d_valid = dv;
    @(posedge clk);
    model_edge(r, e, f, dd, dv);
    #1;
    check(tag);
    $display("step %-8s srst_n=%0b en=%0b flush=%0b d=%0h dv=%0b -> q=%0h qv=%0b count=%0d",
             tag, r, e, f, dd, dv, q, q_valid, count);
  endtask

  initial begin
    srst_n  = 1'b0;
    en      = 1'b1;
    flush   = 1'b0;
    d       = 2'b11;
    d_valid = 1'b1;
    model_reset();

    // Reset held for two edges with live inputs.
    step("reset", 0, 1, 0, 2'b11, 1);
    step("reset", 0, 1, 0, 2'b11, 1);
    #2;
    d = 2'b01;
    #1;
    check("rst_mid");

    // Latency: three valid beats then an invalid one, then drain.
    step("latency", 1, 1, 0, 2'b01, 1);
    step("latency", 1, 1, 0, 2'b10, 1);
    step("latency", 1, 1, 0, 2'b11, 1);
    step("latency", 1, 1, 0, 2'b00, 0);
    step("latency", 1, 1, 0, 2'b00, 0);
    step("latency", 1, 1, 0, 2'b00, 0);
    step("latency", 1, 1, 0, 2'b00, 0);

    // Stall: two valid beats, freeze for three edges with D moving, then drain.
    step("stall", 1, 1, 0, 2'b10, 1);
    step("stall", 1, 1, 0, 2'b01, 1);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 2'(i + 1), 1'(i));
    for (int i = 0; i < 6; i++) step("stall", 1, 1, 0, 2'b00, 0);

    // Full: continuous valid beats saturate the count at DEPTH.
    for (int i = 0; i < 10; i++) step("full", 1, 1, 0, 2'($urandom_range(0, 3)), 1);

    // Mid-stream reset with three beats in flight.
    step("midrst", 1, 1, 0, 2'b00, 0);
    step("midrst", 0, 1, 0, 2'b11, 1);
    for (int i = 0; i < 6; i++) step("midrst", 1, 1, 0, 2'($urandom_range(0, 3)), 1);

    // SRST_N pulsed low between edges must have no effect.
    #2;
    srst_n = 1'b0;
    #2;
    check("noasync");
    srst_n = 1'b1;
    step("noasync", 1, 1, 0, 2'b10, 0);

`ifdef SDFF_PIPE_FLUSH_EN
    // Flush while stalled: valid beats vanish, data stays, flush-edge beat never emerges.
    step("flush", 1, 1, 0, 2'b01, 1);
    step("flush", 1, 1, 0, 2'b11, 1);
    step("flush", 1, 1, 0, 2'b10, 1);
    step("flush", 1, 0, 1, 2'b11, 1);
    for (int i = 0; i < 5; i++) step("flush", 1, 1, 0, 2'($urandom_range(0, 3)), 0);
    step("flush", 1, 1, 1, 2'b01, 1);
    for (int i = 0; i < 5; i++) step("flush", 1, 1, 0, 2'b00, 0);
`endif

    // Randomized traffic with occasional stalls, resets and flushes.
    for (int i = 0; i < 300; i++) begin
      logic r, e, f;
      r = ($urandom_range(0, 24) != 0);
      e = ($urandom_range(0, 3) != 0);
`ifdef SDFF_PIPE_FLUSH_EN
      f = ($urandom_range(0, 19) == 0);
`else
      f = 1'b0;
`endif
      step("random", r, e, f, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of stimulus");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sdff_pipe.md
# sdff_pipe

Parametrised delay line built from synchronous-reset D flip-flops: WIDTH-bit data with a valid flag, DEPTH stages, global clock enable and an in-flight occupancy count. It generalises the single-stage synchronous-reset DFF in the flip-flop test set: multi-bit, multi-stage, stallable, with valid tracking. It is a reference block for signal-flow and timing-analysis tests.

## Interface
- WIDTH, 2: data width in bits; must be ≥ 1.
- DEPTH, 4: number of register stages; must be ≥ 1.
- RST_VAL, {WIDTH{1'b0}}: value loaded into every data stage on reset.
- CNTW, $clog2(DEPTH+1): derived width of COUNT; not overridden.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- SRST_N  in  1  synchronous active-low reset.
- EN  in  1  stage enable; 0 freezes the whole line.
- D  in  WIDTH  input data.
- D_VALID  in  1  qualifies D.
- FLUSH  in  1  invalidates the contents of the line (present only with SDFF_PIPE_FLUSH_EN).
- Q  out  WIDTH  data output of the last stage, registered.
- Q_VALID  out  1  valid flag of the last stage, registered.
- COUNT  out  CNTW  number of valid beats currently held in the line, registered.

## Operation
- Each stage i holds data[i] and vld[i]. Q = data[DEPTH-1]. Q_VALID = vld[DEPTH-1].
- Priority at each rising edge: reset, then flush, then enable, then hold.
- Reset (SRST_N=0 at the edge): every data[i] ← RST_VAL, every vld[i] ← 0, COUNT ← 0. EN, FLUSH, D and D_VALID are ignored. There is no asynchronous path: SRST_N falling between edges changes nothing until the next edge.
- Enable (EN=1):
  - data[0] ← D and vld[0] ← D_VALID.
  - data[i] ← data[i-1] and vld[i] ← vld[i-1] for 0 < i < DEPTH.
  - Data shifts whether or not it is valid; data is never gated by valid.
- Hold (EN=0): all stages and COUNT keep their values.
- COUNT update on an enabled edge: COUNT ← COUNT + D_VALID − vld[DEPTH-1].
  - Always equals popcount(vld).
  - Range is 0..DEPTH. It cannot overflow or underflow, so no wrap logic is needed.
  - At full (COUNT=DEPTH) with D_VALID=1, COUNT stays at DEPTH: one beat enters and one leaves.
- DEPTH=1 is legal: a single stallable sync-reset register, with COUNT 1 bit wide.

## Timing
- Latency: a beat presented on the edge of its k-th enabled cycle appears on Q/Q_VALID after exactly DEPTH enabled edges. EN=0 edges add no progress.
- Throughput: one beat per enabled cycle. There is no backpressure output.
- Outputs change only after a rising edge. There are no combinational paths from any input to any output.
- Reset values: Q = RST_VAL, Q_VALID = 0, COUNT = 0, all visible after the first edge with SRST_N=0.
- Reset asserted in the middle of streaming discards every in-flight beat on that edge. The first enabled edge after SRST_N returns high loads stage 0 normally.
- Simultaneous EN=1 and SRST_N=0: reset wins.

## Configuration
- SDFF_PIPE_FLUSH_EN defined:
  - The FLUSH port exists.
  - An edge with SRST_N=1 and FLUSH=1 clears every vld[i] and sets COUNT ← 0, regardless of EN.
  - Data stages shift if EN=1 and hold if EN=0; they are not reset.
  - D_VALID on that edge is discarded, so vld[0] ← 0.
- SDFF_PIPE_FLUSH_EN undefined: there is no FLUSH port, and behaviour is identical to FLUSH tied to 0.

## Test plan
All scenarios use WIDTH=2, DEPTH=4, RST_VAL=2'b00.
- Reset: hold SRST_N=0 for 2 edges with D=2'b11, D_VALID=1, EN=1 → Q=00, Q_VALID=0, COUNT=0 throughout. Values are unchanged at any time between edges.
- Latency: release reset, then EN=1 and D=01, 10, 11, 00, with D_VALID=1 on the first three beats and 0 on the fourth → Q shows 01, 10, 11 on edges 4, 5, 6. Q_VALID is high only on those edges. COUNT reads 1, 2, 3, 3, 2, 1, 0.
- Stall: after loading 2 valid beats, drive EN=0 for 3 edges with D changing → Q, Q_VALID and COUNT frozen. After resuming, output timing is shifted by exactly 3 cycles.
- Full: drive D_VALID=1 continuously → COUNT saturates naturally at 4 and stays at 4. Q follows D with a 4-cycle delay.
- Mid-stream reset: with COUNT=3, pull SRST_N low for one edge while EN=1 → next-edge COUNT=0, Q=00, Q_VALID=0. Post-release data resumes with 4-cycle latency and no stale beats emerge.
- Flush (macro defined): with COUNT=3, EN=0, FLUSH=1 for one edge → COUNT=0 and Q_VALID=0 for the following 4 enabled edges. Q data bits are still the old data values. A D_VALID=1 beat presented during the flush edge never emerges.
